// File: rtl/duty_ramp_ctrl.sv
// Slews an 11-bit PWM duty toward an accepted target by at most STEP per 2048-cycle PWM period.
// One-cycle registered duty/state; tgt_rdy drops only in FAULT or while fault is high.
module duty_ramp_ctrl #(
  parameter logic [10:0] STEP     = 11'd16,
  parameter logic [10:0] MAX_DUTY = 11'd2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] tgt_duty,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  input  logic        fault,
  input  logic        fault_clr,
  output logic [10:0] duty,
  output logic        period_start,
  output logic        at_target,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [10:0] pcnt;
  logic [10:0] tgt, tgt_nxt, duty_nxt;
  logic [10:0] tgt_clamp, duty_step, duty_gap;
  logic [11:0] duty_up;
  logic        boundary, accept;

  assign boundary  = (pcnt == 11'd2047);
  assign tgt_rdy   = (state != FAULT) && !fault;
  assign accept    = tgt_vld && tgt_rdy;
  assign tgt_clamp = (tgt_duty > MAX_DUTY) ? MAX_DUTY : tgt_duty;
  assign at_target = (duty == tgt) && (state != FAULT);
  assign state_o   = state;

  // One period's step toward the current tgt; the sum is kept 12 bits wide so it cannot wrap.
  always_comb begin
    duty_up  = {1'b0, duty} + {1'b0, STEP};
    duty_gap = duty - tgt;
    if (duty < tgt)
      duty_step = (duty_up >= {1'b0, tgt}) ? tgt : duty_up[10:0];
    else if (duty_gap <= STEP)
      duty_step = tgt;
    else
      duty_step = duty - STEP;
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    tgt_nxt   = tgt;
    if (fault) begin
      state_nxt = FAULT;
      duty_nxt  = 11'd0;
      tgt_nxt   = 11'd0;
    end else begin
      if (accept)
        tgt_nxt = tgt_clamp;
      case (state)
        IDLE: if (accept && (tgt_clamp != 11'd0)) state_nxt = RAMP;
        RAMP: begin
          // duty_step is built from the old tgt, so a target landing on a boundary waits a period
          if (boundary)
            duty_nxt = duty_step;
          if (duty_nxt == tgt_nxt)
            state_nxt = (tgt_nxt != 11'd0) ? HOLD : IDLE;
        end
        HOLD: if (accept && (tgt_clamp != duty)) state_nxt = RAMP;
        FAULT: if (fault_clr) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt         <= 11'd0;
      period_start <= 1'b0;
      state        <= IDLE;
      duty         <= 11'd0;
      tgt          <= 11'd0;
    end else begin
      pcnt         <= pcnt + 11'd1;
      period_start <= boundary;
      state        <= state_nxt;
      duty         <= duty_nxt;
      tgt          <= tgt_nxt;
    end
  end

endmodule

// File: doc/duty_ramp_ctrl.md
DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 Parameter STEP, default 11'd16: maximum duty change per PWM period; legal range 1..2047.
REQ-002 Parameter MAX_DUTY, default 11'd2047: saturation ceiling for accepted targets.
REQ-003 clk  input  1  system clock, same clock as the 11-bit PWM generator it drives.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tgt_duty  input  11  requested target duty.
REQ-006 tgt_vld  input  1  tgt_duty valid.
REQ-007 tgt_rdy  output  1  block can accept a target.
REQ-008 fault  input  1  level-sensitive fault; forces output duty to zero.
REQ-009 fault_clr  input  1  single-cycle request to leave FAULT.
REQ-010 duty  output  11  registered duty to the PWM generator.
REQ-011 period_start  output  1  high for the single cycle in which pcnt==0.
REQ-012 at_target  output  1  duty==tgt and state!=FAULT.
REQ-013 state_o  output  2  current state: IDLE=0, RAMP=1, HOLD=2, FAULT=3.

Function
REQ-014 An internal 11-bit period counter pcnt shall increment every clk and wrap 2047->0, so it stays in lockstep with a PWM generator reset by the same rst_n.
REQ-015 A "boundary" shall be the clock edge on which pcnt goes 2047->0; duty shall change only on a boundary, except on a fault.
REQ-016 tgt_rdy shall equal (state!=FAULT) and !fault.
REQ-017 A target is accepted on an edge with tgt_vld and tgt_rdy high; the internal tgt register then loads min(tgt_duty, MAX_DUTY).
REQ-018 A target accepted during RAMP shall replace the previous target; ramp direction may reverse.
REQ-019 On a boundary in RAMP with duty<tgt, duty shall load min(duty+STEP, tgt), computed in 12 bits with no wrap.
REQ-020 On a boundary in RAMP with duty>tgt, duty shall load tgt if (duty-tgt)<=STEP, else duty-STEP; there shall be no underflow.
REQ-021 When a target is accepted on a boundary edge, that boundary step shall use the old tgt; the new tgt takes effect at the next boundary.
REQ-022 IDLE (duty==0, tgt==0): on accept with clamped target !=0, go to RAMP; on accept of 0, stay.
REQ-023 RAMP: when the updated duty equals tgt, go to HOLD if tgt!=0, else IDLE.
REQ-024 HOLD: on accept with clamped target !=duty, go to RAMP; on accept of a target equal to duty, stay.
REQ-025 In any state, fault high at an edge shall force duty<=0, tgt<=0 and state<=FAULT on that edge; fault takes priority over accept and boundary.
REQ-026 In FAULT, go to IDLE on the edge where fault_clr==1 and fault==0; fault_clr while fault is high shall be ignored.
REQ-027 pcnt shall keep running in every state, including FAULT.

Reset
REQ-028 While rst_n is low: pcnt=0, duty=0, tgt=0, state=IDLE, period_start=0, at_target=1, tgt_rdy=1 (provided fault is low).
REQ-029 Reset asserted mid-ramp shall abort immediately, with outputs as in REQ-028; no ramp history survives.

Verification
REQ-030 Defaults, reset, accept tgt=100 at cycle 5 -> duty = 16,32,48,64,80,96,100 on boundaries 1-7 -> HOLD, at_target=1.
REQ-031 From HOLD at 100, accept 0 -> duty = 84,68,...,4,0 on successive boundaries -> IDLE.
REQ-032 fault=1 mid-ramp at duty 48 -> duty=0 on next edge, tgt_rdy=0, tgt_vld ignored -> fault_clr with fault high is ignored -> fault low then fault_clr -> IDLE, tgt_rdy=1.
REQ-033 MAX_DUTY=1500, accept 2000 -> tgt=1500 -> ramp ends at duty=1500.
REQ-034 In RAMP toward 100 at duty 32, accept tgt=20 on the pcnt==2047 edge -> duty=48 at that boundary, then 32, 20 -> HOLD.
REQ-035 Assert rst_n low at duty 64 mid-ramp -> duty=0, pcnt=0, IDLE; period_start first pulses 2048 cycles after release.
